// File: rtl/halt_ctrl.sv
// Halt sequencer: on ebreak retire, stall the core, drain in-flight writebacks,
// stream all 32 GPRs to the host, then hold halted until resumed.
module halt_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [31:0] EBREAK_INST  = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid_i,
  input  logic [31:0] commit_inst_i,
  input  logic [63:0] commit_pc_i,
  output logic        stall_o,
  output logic        gpr_rsel_o,
  output logic [4:0]  gpr_raddr_o,
  input  logic [63:0] gpr_rdata_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [4:0]  dump_idx_o,
  output logic [63:0] dump_data_o,
  output logic        halt_o,
  output logic [63:0] halt_pc_o,
  output logic [63:0] exit_code_o,
  output logic        good_trap_o,
  output logic [63:0] inst_cnt_o,
  input  logic        resume_i
);

  typedef enum logic [1:0] {StRun, StDrain, StDump, StHalted} state_e;

  localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [63:0] halt_pc_q, halt_pc_d;
  logic [63:0] exit_code_q, exit_code_d;
  logic [63:0] inst_cnt_q, inst_cnt_d;
  logic        stall_q, rsel_q, valid_q, halt_q;
  logic        is_ebreak, beat_done;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    idx_d       = idx_q;
    halt_pc_d   = halt_pc_q;
    exit_code_d = exit_code_q;
    inst_cnt_d  = inst_cnt_q;
    is_ebreak   = commit_valid_i && (commit_inst_i == EBREAK_INST);
    beat_done   = valid_q && dump_ready_i;

    if (commit_valid_i) begin
      inst_cnt_d = inst_cnt_q + 64'd1;
    end

    unique case (state_q)
      StRun: begin
        if (is_ebreak) begin
          state_d     = StDrain;
          halt_pc_d   = commit_pc_i;
          drain_cnt_d = DrainLoad;
        end
      end
      StDrain: begin
        if (drain_cnt_q == 4'd0) begin
          state_d = StDump;
        end else begin
          drain_cnt_d = drain_cnt_q - 4'd1;
        end
      end
      StDump: begin
        if (beat_done) begin
          // Index wraps 31 -> 0, so the next dump starts from x0 again.
          idx_d = idx_q + 5'd1;
          if (idx_q == 5'd10) begin
            exit_code_d = gpr_rdata_i;
          end
          if (idx_q == 5'd31) begin
            state_d = StHalted;
          end
        end
      end
      StHalted: begin
        if (resume_i) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Output flags are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      drain_cnt_q <= 4'd0;
      idx_q       <= 5'd0;
      halt_pc_q   <= 64'd0;
      exit_code_q <= 64'd0;
      inst_cnt_q  <= 64'd0;
      stall_q     <= 1'b0;
      rsel_q      <= 1'b0;
      valid_q     <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      idx_q       <= idx_d;
      halt_pc_q   <= halt_pc_d;
      exit_code_q <= exit_code_d;
      inst_cnt_q  <= inst_cnt_d;
      stall_q     <= (state_d != StRun);
      rsel_q      <= (state_d == StDump);
      valid_q     <= (state_d == StDump);
      halt_q      <= (state_d == StHalted);
    end
  end

  assign stall_o      = stall_q;
  assign gpr_rsel_o   = rsel_q;
  assign gpr_raddr_o  = idx_q;
  assign dump_valid_o = valid_q;
  assign dump_idx_o   = idx_q;
  assign dump_data_o  = gpr_rdata_i;
  assign halt_o       = halt_q;
  assign halt_pc_o    = halt_pc_q;
  assign exit_code_o  = exit_code_q;
  assign good_trap_o  = halt_q && (exit_code_q == 64'd0);
  assign inst_cnt_o   = inst_cnt_q;

endmodule

// File: tb/tb_halt_ctrl.sv
// Directed bench for halt_ctrl: halt/drain/dump/resume sequencing, reset abort,
// backpressure and counter wrap against hand-computed expectations.
module tb_halt_ctrl;

  localparam logic [31:0] Ebreak = 32'h0010_0073;
  localparam logic [31:0] Nop    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid_i;
  logic [31:0] commit_inst_i;
  logic [63:0] commit_pc_i;
  logic        stall_o, gpr_rsel_o, dump_valid_o, dump_ready_i;
  logic [4:0]  gpr_raddr_o, dump_idx_o;
  logic [63:0] gpr_rdata_i, dump_data_o, halt_pc_o, exit_code_o, inst_cnt_o;
  logic        halt_o, good_trap_o, resume_i;

  logic [63:0] regs [32];
  int n_vec = 0;
  int n_err = 0;

  assign gpr_rdata_i = regs[gpr_raddr_o];

  always #5 clk = ~clk;

  halt_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .commit_valid_i (commit_valid_i),
    .commit_inst_i  (commit_inst_i),
    .commit_pc_i    (commit_pc_i),
    .stall_o        (stall_o),
    .gpr_rsel_o     (gpr_rsel_o),
    .gpr_raddr_o    (gpr_raddr_o),
    .gpr_rdata_i    (gpr_rdata_i),
    .dump_valid_o   (dump_valid_o),
    .dump_ready_i   (dump_ready_i),
    .dump_idx_o     (dump_idx_o),
    .dump_data_o    (dump_data_o),
    .halt_o         (halt_o),
    .halt_pc_o      (halt_pc_o),
    .exit_code_o    (exit_code_o),
    .good_trap_o    (good_trap_o),
    .inst_cnt_o     (inst_cnt_o),
    .resume_i       (resume_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    commit_valid_i = 1'b0;
    commit_inst_i  = Nop;
    commit_pc_i    = 64'd0;
    resume_i       = 1'b0;
    dump_ready_i   = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_regs(input logic [63:0] x10);
    for (int i = 0; i < 32; i++) regs[i] = 64'hA5A5_0000_0000_0000 | 64'(i * 17);
    regs[0]  = 64'd0;
    regs[10] = x10;
  endtask

  task automatic commit(input logic [31:0] inst, input logic [63:0] pc);
    commit_valid_i = 1'b1;
    commit_inst_i  = inst;
    commit_pc_i    = pc;
    tick();
    commit_valid_i = 1'b0;
  endtask

  // Leaves the DUT on the first DUMP cycle.
  task automatic enter_halt(input int nops, input logic [63:0] pc);
    for (int i = 0; i < nops; i++) begin
      commit(Nop, 64'h1000 + 64'(4 * i));
      check("run_stall", stall_o, 1'b0);
    end
    commit(Ebreak, pc);
    check("drain1_stall", stall_o, 1'b1);
    check("drain1_valid", dump_valid_o, 1'b0);
    check("cnt_after_ebreak", inst_cnt_o, 64'(nops + 1));
    tick();
    check("drain2_stall", stall_o, 1'b1);
    check("drain2_valid", dump_valid_o, 1'b0);
    tick();
    check("dump_valid", dump_valid_o, 1'b1);
    check("dump_rsel", gpr_rsel_o, 1'b1);
    check("dump_start_idx", dump_idx_o, 64'd0);
  endtask

  task automatic dump_phase(input bit rnd);
    int exp_i = 0;
    int cyc   = 0;
    while (exp_i < 32 && cyc < 500) begin
      dump_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dump_valid_o) begin
        check("beat_idx", dump_idx_o, 64'(exp_i));
        check("beat_raddr", gpr_raddr_o, 64'(exp_i));
        check("beat_data", dump_data_o, regs[exp_i]);
        if (dump_ready_i) exp_i++;
      end
      tick();
      cyc++;
    end
    dump_ready_i = 1'b1;
    check("beats_accepted", 64'(exp_i), 64'd32);
  endtask

  task automatic check_halted(input logic [63:0] pc, input logic [63:0] x10,
                              input logic [63:0] cnt);
    check("halt", halt_o, 1'b1);
    check("halt_valid", dump_valid_o, 1'b0);
    check("halt_rsel", gpr_rsel_o, 1'b0);
    check("halt_stall", stall_o, 1'b1);
    check("halt_pc", halt_pc_o, pc);
    check("exit_code", exit_code_o, x10);
    check("good_trap", good_trap_o, (x10 == 64'd0) ? 64'd1 : 64'd0);
    check("halt_cnt", inst_cnt_o, cnt);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_stall"}, stall_o, 1'b0);
    check({tag, "_valid"}, dump_valid_o, 1'b0);
    check({tag, "_rsel"}, gpr_rsel_o, 1'b0);
    check({tag, "_raddr"}, gpr_raddr_o, 64'd0);
    check({tag, "_idx"}, dump_idx_o, 64'd0);
    check({tag, "_halt"}, halt_o, 1'b0);
    check({tag, "_good"}, good_trap_o, 1'b0);
    check({tag, "_pc"}, halt_pc_o, 64'd0);
    check({tag, "_exit"}, exit_code_o, 64'd0);
    check({tag, "_cnt"}, inst_cnt_o, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    load_regs(64'd0);
    do_reset();
    check_reset_vals("reset");

    // Clean halt with x10 = 0.
    enter_halt(5, 64'h8000_0010);
    dump_phase(1'b0);
    check_halted(64'h8000_0010, 64'd0, 64'd6);

    // Nonzero exit code, random backpressure, then resume.
    do_reset();
    load_regs(64'h2A);
    enter_halt(5, 64'h8000_0010);
    dump_phase(1'b1);
    check_halted(64'h8000_0010, 64'h2A, 64'd6);
    resume_i = 1'b1;
    tick();
    resume_i = 1'b0;
    check("resume_halt", halt_o, 1'b0);
    check("resume_stall", stall_o, 1'b0);
    check("resume_cnt", inst_cnt_o, 64'd6);
    check("resume_pc", halt_pc_o, 64'h8000_0010);
    check("resume_exit", exit_code_o, 64'h2A);
    check("resume_good", good_trap_o, 1'b0);
    resume_i = 1'b1;
    tick();
    resume_i = 1'b0;
    check("resume_in_run_stall", stall_o, 1'b0);
    check("resume_in_run_halt", halt_o, 1'b0);
    commit(Nop, 64'h2000);
    check("cnt_after_resume", inst_cnt_o, 64'd7);

    // Second ebreak during DRAIN.
    do_reset();
    load_regs(64'd5);
    commit(Ebreak, 64'h8000_0100);
    check("dbl_stall1", stall_o, 1'b1);
    commit(Ebreak, 64'h8000_0200);
    check("dbl_stall2", stall_o, 1'b1);
    check("dbl_valid2", dump_valid_o, 1'b0);
    check("dbl_cnt", inst_cnt_o, 64'd2);
    tick();
    check("dbl_dump_valid", dump_valid_o, 1'b1);
    dump_phase(1'b0);
    check_halted(64'h8000_0100, 64'd5, 64'd2);
    tick();
    tick();
    check("dbl_no_redump", dump_valid_o, 1'b0);
    check("dbl_still_halt", halt_o, 1'b1);

    // Reset at beat 12, dominating commit and resume.
    do_reset();
    load_regs(64'h77);
    enter_halt(0, 64'h8000_0300);
    for (int i = 0; i < 12; i++) begin
      check("pre_abort_idx", dump_idx_o, 64'(i));
      tick();
    end
    check("abort_idx12", dump_idx_o, 64'd12);
    check("abort_exit_captured", exit_code_o, 64'h77);
    rst            = 1'b1;
    commit_valid_i = 1'b1;
    commit_inst_i  = Ebreak;
    commit_pc_i    = 64'h9000_0000;
    resume_i       = 1'b1;
    tick();
    rst            = 1'b0;
    commit_valid_i = 1'b0;
    resume_i       = 1'b0;
    check_reset_vals("abort");
    tick();
    check("abort_no_beat", dump_valid_o, 1'b0);
    enter_halt(0, 64'h8000_0400);
    dump_phase(1'b0);
    check_halted(64'h8000_0400, 64'h77, 64'd1);

    // Counter wrap from a preloaded value.
    do_reset();
    force dut.inst_cnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    release dut.inst_cnt_q;
    check("wrap_preload", inst_cnt_o, 64'hFFFF_FFFF_FFFF_FFFE);
    commit(Nop, 64'h3000);
    check("wrap_max", inst_cnt_o, 64'hFFFF_FFFF_FFFF_FFFF);
    commit(Nop, 64'h3004);
    check("wrap_zero", inst_cnt_o, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/halt_ctrl.md
HALT_CTRL -- requirements
Module: halt_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2, is the number of cycles waited after ebreak retire for in-flight writebacks; legal range 1..15.
REQ-002 Parameter EBREAK_INST, default 32'h0010_0073, is the instruction encoding that triggers halt.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 commit_valid_i  input  1  one instruction retires this cycle.
REQ-006 commit_inst_i  input  32  encoding of the retiring instruction.
REQ-007 commit_pc_i  input  64  PC of the retiring instruction.
REQ-008 stall_o  output  1  freezes fetch and pipeline advance.
REQ-009 gpr_rsel_o  output  1  controller owns the regfile debug read port.
REQ-010 gpr_raddr_o  output  5  regfile read index.
REQ-011 gpr_rdata_i  input  64  combinational regfile read data for gpr_raddr_o.
REQ-012 dump_valid_o / dump_ready_i  output / input  1 / 1  GPR snapshot stream handshake to host.
REQ-013 dump_idx_o  output  5  register index of the current beat.
REQ-014 dump_data_o  output  64  register value of the current beat.
REQ-015 halt_o  output  1  snapshot complete, core halted.
REQ-016 halt_pc_o  output  64  PC of the halting ebreak.
REQ-017 exit_code_o  output  64  value of x10 (a0) at halt.
REQ-018 good_trap_o  output  1  halt_o AND exit_code_o == 0.
REQ-019 inst_cnt_o  output  64  retired-instruction counter.
REQ-020 resume_i  input  1  single-cycle pulse; leave HALTED and run again.

Function
REQ-021 States SHALL be RUN, DRAIN, DUMP, HALTED, encoded in registered state.
REQ-022 inst_cnt_o SHALL increment by 1 on every cycle with commit_valid_i=1 in any state, including the ebreak itself, wrapping 2^64-1 -> 0.
REQ-023 RUN: commit_valid_i=1 with commit_inst_i==EBREAK_INST at cycle N SHALL latch halt_pc_o=commit_pc_i and enter DRAIN at N+1.
REQ-024 stall_o SHALL be 1 in DRAIN, DUMP and HALTED, 0 in RUN (registered; first high at N+1).
REQ-025 DRAIN SHALL last exactly DRAIN_CYCLES cycles via a down-counter, then enter DUMP.
REQ-026 ebreak commits in DRAIN/DUMP/HALTED SHALL be counted but SHALL NOT re-latch halt_pc_o or restart sequencing.
REQ-027 DUMP: gpr_rsel_o=1, gpr_raddr_o=dump_idx_o, dump_data_o=gpr_rdata_i, dump_valid_o=1; dump_idx_o starts at 0.
REQ-028 A beat SHALL complete on dump_valid_o AND dump_ready_i; dump_idx_o then increments; idx/data SHALL be held stable while valid and not ready.
REQ-029 On the completing beat with dump_idx_o==10, exit_code_o SHALL capture dump_data_o.
REQ-030 Completion of beat 31 SHALL enter HALTED next cycle; dump_valid_o and gpr_rsel_o drop to 0, halt_o rises to 1.
REQ-031 HALTED: resume_i=1 SHALL enter RUN next cycle, clear halt_o, keep inst_cnt_o, halt_pc_o, exit_code_o.
REQ-032 resume_i outside HALTED SHALL be ignored.
REQ-033 gpr_rsel_o, dump_valid_o SHALL be 0 outside DUMP; halt_o 0 outside HALTED.

Reset
REQ-034 rst=1 SHALL force state RUN and, in the same edge, stall_o=0, gpr_rsel_o=0, gpr_raddr_o=0, dump_valid_o=0, dump_idx_o=0, halt_o=0, good_trap_o=0, halt_pc_o=0, exit_code_o=0, inst_cnt_o=0, DRAIN counter=0.
REQ-035 rst asserted mid-DRAIN or mid-DUMP SHALL abort the sequence with no further beats; rst dominates commit_valid_i and resume_i in the same cycle.

Verification
REQ-036 5 non-ebreak commits then ebreak at pc 0x8000_0010, ready tied 1, x10=0 -> stall_o high next cycle, 2 DRAIN cycles, 32 beats idx 0..31 back-to-back, halt_o=1, good_trap_o=1, halt_pc_o=0x8000_0010, inst_cnt_o=6.
REQ-037 Same with x10=0x2A -> exit_code_o=0x2A, good_trap_o=0.
REQ-038 dump_ready_i toggled 0/1 randomly -> 32 beats each accepted once, idx/data stable while stalled, order 0..31.
REQ-039 Second ebreak commits during DRAIN -> inst_cnt_o counts both, halt_pc_o keeps first PC, single dump.
REQ-040 rst at beat 12 -> outputs at reset values next cycle; new ebreak restarts dump at idx 0.
REQ-041 resume_i in HALTED -> RUN next cycle, stall_o=0, halt_o=0, inst_cnt_o retained; inst_cnt preloaded near 2^64-1 wraps to 0.
